uartprobe_cmdproc: RTL
======================

// Module: uartprobe_cmdproc
// PURPOSE
//  Byte-stream command processor between the UART wrapper (rx/tx valid/ready byte ports) and the probe targets.
//  Parametrised successor of the fixed single-32b-GPIO probe: N GPO/GPI channels of GPIO_W bits each.
//  Adds a single-beat AXI master (one outstanding transaction) and a status/ack byte returned for every command.
// PARAMETERS
//  N_CH        4             number of GPO channels and of GPI channels (1..16)
//  GPIO_W      32            bits per channel; multiple of 8, 8..64
//  GPO_RESET   0             reset value of every GPO channel (GPIO_W bits)
//  RX_TIMEOUT  1_000_000     idle cycles between argument bytes before abort (used only with the macro)
// PORTS
//  clk         in   1           clock
//  reset       in   1           synchronous reset, active-high
//  rx_valid    in   1           received byte valid
//  rx_data     in   8           received byte
//  rx_ready    out  1           byte accepted when rx_valid&&rx_ready
//  tx_valid    out  1           response byte valid
//  tx_data     out  8           response byte
//  tx_ready    in   1           UART accepts the byte
//  gpo         out  N_CH*GPIO_W channel k = gpo[k*GPIO_W +: GPIO_W]
//  gpi         in   N_CH*GPIO_W same packing as gpo
//  m_axi_*     AXI4 AW/W/B/AR/R subset: 32b address, 32b data; arsize=awsize=3'b010, wstrb=4'hF, wlast=1
// BEHAVIOUR
//  Command byte = {op[7:4], ch[3:0]}; arguments follow MSB-first. B = GPIO_W/8.
//  op 1 GPO_WR: B data bytes -> gpo[ch] updated the cycle after the last byte; reply 0xA5.
//  op 2 GPI_RD: no args -> gpi[ch] sampled on the cycle the command byte is accepted; reply B bytes, MSB first.
//  op 3 AXI_WR: 4 addr + 4 data bytes -> reply {6'b0,bresp}.
//  op 4 AXI_RD: 4 addr bytes -> reply {6'b0,rresp} followed by 4 rdata bytes, MSB first.
//  Any other op, or ch>=N_CH on op 1/2: all argument bytes are NOT consumed; reply 0xEE immediately.
//  FSM: IDLE -> ARGS (arg count>0) -> EXEC | AXI_AW_W -> AXI_B | AXI_AR -> AXI_R -> TX -> IDLE.
//  rx_ready=1 only in IDLE and ARGS. Byte counter: counts down from argument count; 0 -> execute.
//  Response shift register: max(B,5) bytes plus a length counter. tx_valid holds and tx_data is stable
//   until tx_ready; a byte is shifted out on each tx handshake; TX -> IDLE after the last byte.
//  AXI_AW_W: awvalid and wvalid rise together; each drops on its own ready. Both done -> AXI_B with bready=1.
//  AXI_AR: arvalid=1 until arready. AXI_R: rready=1; capture rdata/rresp on rvalid.
//  rlast is ignored. No AXI timeout: the FSM waits indefinitely for a response.
//  Next command byte is not accepted until the last response byte handshakes (strictly one command in flight).
//  Reset values: rx_ready=0 (1 from the first cycle after reset), tx_valid=0, tx_data=0, gpo=GPO_RESET,
//   all m_axi valid/ready=0, addr/data=0.
//  Reset mid-transaction: FSM returns to IDLE and valids drop. Any in-flight AXI response is discarded.
//   Software must re-sync after reset.
// CONFIGURATION
//  UARTPROBE_RX_TIMEOUT_EN defined: in ARGS a counter clears on every rx byte.
//   On reaching RX_TIMEOUT: discard the partial command, reply 0xEF, return to IDLE.
//   Not active in IDLE or the AXI/TX states.
//  Undefined: ARGS waits forever. No counter logic is synthesised and 0xEF is never produced.
// STRUCTURE
//  Package uartprobe_pkg: opcode localparams (OP_GPO_WR=4'h1, OP_GPI_RD=4'h2, OP_AXI_WR=4'h3, OP_AXI_RD=4'h4);
//   reply constants (ACK=8'hA5, ERR=8'hEE, TMO=8'hEF); FSM state encoding.
//  Sub-module uartprobe_txshift: loadable response shift register + tx valid/ready handshake.
//   The parser/FSM and the AXI logic stay in this module.
// TESTING
//  1 N_CH=4, GPIO_W=32: send 0x12,DE,AD,BE,EF -> gpo[2]=0xDEADBEEF, others=GPO_RESET; reply 0xA5.
//  2 gpi[1]=0x01234567; send 0x21 -> replies 0x01,0x23,0x45,0x67; tx_ready toggling 1/0 -> bytes unchanged, no loss.
//  3 send 0x30,00,00,10,00,CA,FE,F0,0D with awready delayed 3 cycles and wready immediate:
//     single AW@0x1000, W 0xCAFEF00D; bresp=2 -> reply 0x02.
//  4 send 0x40,00,00,20,00; slave returns rdata 0x89ABCDEF, rresp=0 -> replies 0x00,0x89,0xAB,0xCD,0xEF.
//  5 send 0x17 (ch>=N_CH) and 0x90 (bad op) -> reply 0xEE each; gpo unchanged; next valid command works.
//  6 With UARTPROBE_RX_TIMEOUT_EN, RX_TIMEOUT=100: send 0x10,AA then idle 100 cycles -> reply 0xEF; gpo unchanged.
//    Also: reset asserted during AXI_R -> all outputs back to reset values the next cycle.

Source files
------------

// File: rtl/uartprobe_pkg.sv
// Shared definitions for the UART probe command processor.
//   - Opcodes carried in the upper nibble of a command byte.
//   - Single-byte reply codes.
//   - FSM state encoding used by uartprobe_cmdproc.
// Optional feature macro (see uartprobe_cmdproc): UARTPROBE_RX_TIMEOUT_EN.
package uartprobe_pkg;

  localparam logic [3:0] OP_GPO_WR = 4'h1;
  localparam logic [3:0] OP_GPI_RD = 4'h2;
  localparam logic [3:0] OP_AXI_WR = 4'h3;
  localparam logic [3:0] OP_AXI_RD = 4'h4;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] ERR = 8'hEE;
  localparam logic [7:0] TMO = 8'hEF;

  // Argument byte counts of the AXI commands (address, plus data for writes).
  localparam logic [3:0] AXI_WR_ARGS = 4'd8;
  localparam logic [3:0] AXI_RD_ARGS = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARGS,
    S_EXEC,
    S_AXI_AW_W,
    S_AXI_B,
    S_AXI_AR,
    S_AXI_R,
    S_TX
  } state_e;

endpackage

// File: rtl/uartprobe_txshift.sv
// Response shift register for the UART probe.
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture load_data / load_len (only pulsed while no reply is pending)
//   load_data   : reply bytes, MSB-aligned; first byte to send in the top byte
//   load_len    : number of valid bytes in load_data
//   tx_valid    : a reply byte is pending
//   tx_data     : current reply byte, stable until tx_ready
//   tx_ready    : UART accepts the byte
//   done        : one-cycle pulse on the handshake of the last byte
module uartprobe_txshift
  import uartprobe_pkg::*;
#(
  parameter int unsigned BYTES = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BYTES*8-1:0] load_data,
  input  logic [3:0]         load_len,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic               done
);

  logic [BYTES*8-1:0] sh_q, sh_d;
  logic [3:0]         len_q, len_d;
  logic               hs;

  always_comb begin
    sh_d  = sh_q;
    len_d = len_q;
    done  = 1'b0;
    hs    = (len_q != 4'd0) && tx_ready;
    if (load) begin
      sh_d  = load_data;
      len_d = load_len;
    end else if (hs) begin
      // Zeros are shifted in so tx_data reads 0 once the reply is gone.
      sh_d  = {sh_q[BYTES*8-9:0], 8'h00};
      len_d = len_q - 4'd1;
      done  = (len_q == 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      len_q <= '0;
    end else begin
      sh_q  <= sh_d;
      len_q <= len_d;
    end
  end

  assign tx_valid = (len_q != 4'd0);
  assign tx_data  = sh_q[BYTES*8-1 -: 8];

endmodule

// File: rtl/uartprobe_cmdproc.sv
// Byte-stream command processor between a UART byte interface and probe targets:
// N_CH general-purpose output/input channels of GPIO_W bits and a single-beat
// AXI4 master (one outstanding transaction). Every command gets a reply.
//   clk, reset          : clock, synchronous active-high reset
//   rx_valid/rx_data/rx_ready : command and argument bytes in
//   tx_valid/tx_data/tx_ready : reply bytes out
//   gpo                 : output channels, channel k at gpo[k*GPIO_W +: GPIO_W]
//   gpi                 : input channels, same packing
//   m_axi_*             : AW/W/B/AR/R subset, 32-bit address and data. rlast is
//                         not brought in: every read is a single beat.
// Optional feature: define UARTPROBE_RX_TIMEOUT_EN to abort a partially received
// command after RX_TIMEOUT idle cycles (reply 0xEF). Undefined: no timeout logic.
module uartprobe_cmdproc
  import uartprobe_pkg::*;
#(
  parameter int unsigned       N_CH       = 4,
  parameter int unsigned       GPIO_W     = 32,
  parameter logic [GPIO_W-1:0] GPO_RESET  = '0,
  parameter int unsigned       RX_TIMEOUT = 1_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  output logic [N_CH*GPIO_W-1:0]   gpo,
  input  logic [N_CH*GPIO_W-1:0]   gpi,
  output logic [31:0]              m_axi_awaddr,
  output logic [2:0]               m_axi_awsize,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [31:0]              m_axi_wdata,
  output logic [3:0]               m_axi_wstrb,
  output logic                     m_axi_wlast,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [31:0]              m_axi_araddr,
  output logic [2:0]               m_axi_arsize,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [31:0]              m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  localparam int unsigned B      = GPIO_W / 8;
  // Longest reply is either a GPI read (B bytes) or an AXI read (status + 4).
  localparam int unsigned RB     = (B > 5) ? B : 5;
  localparam int unsigned RESP_W = RB * 8;

  state_e                  state_q, state_d;
  logic [3:0]              op_q, op_d;
  logic [3:0]              ch_q, ch_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [63:0]             arg_q, arg_d;
  logic [N_CH*GPIO_W-1:0]  gpo_q, gpo_d;
  logic [31:0]             awaddr_q, awaddr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             araddr_q, araddr_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;

`ifdef UARTPROBE_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
`endif

  logic                    ld;
  logic [RESP_W-1:0]       ld_data;
  logic [3:0]              ld_len;
  logic                    tx_done;

  logic                    rx_hs;
  logic                    ch_ok;
  logic                    reject;
  logic [GPIO_W-1:0]       gpi_sel;
  logic [63:0]             arg_shift;

  // Held low while reset is asserted so no byte can be taken during reset.
  assign rx_ready  = !reset && ((state_q == S_IDLE) || (state_q == S_ARGS));
  assign rx_hs     = rx_valid && rx_ready;
  assign ch_ok     = 32'(rx_data[3:0]) < N_CH;
  assign arg_shift = {arg_q[55:0], rx_data};

  // Channel addressed by the byte currently on rx_data (the GPI_RD command).
  always_comb begin
    gpi_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (rx_data[3:0] == 4'(k)) gpi_sel = gpi[k*GPIO_W +: GPIO_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    arg_d     = arg_q;
    gpo_d     = gpo_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    araddr_d  = araddr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    ld        = 1'b0;
    ld_data   = '0;
    ld_len    = '0;
    reject    = 1'b0;
`ifdef UARTPROBE_RX_TIMEOUT_EN
    tmo_d     = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_hs) begin
          op_d = rx_data[7:4];
          ch_d = rx_data[3:0];
          case (rx_data[7:4])
            OP_GPO_WR: begin
              if (ch_ok) begin
                cnt_d   = 4'(B);
                state_d = S_ARGS;
              end else begin
                reject = 1'b1;
              end
            end
            OP_GPI_RD: begin
              // Sampled in the same cycle the command byte is accepted.
              if (ch_ok) begin
                ld                           = 1'b1;
                ld_data[RESP_W-1 -: GPIO_W]  = gpi_sel;
                ld_len                       = 4'(B);
                state_d                      = S_TX;
              end else begin
                reject = 1'b1;
              end
            end
            OP_AXI_WR: begin
              cnt_d   = AXI_WR_ARGS;
              state_d = S_ARGS;
            end
            OP_AXI_RD: begin
              cnt_d   = AXI_RD_ARGS;
              state_d = S_ARGS;
            end
            default: reject = 1'b1;
          endcase
          // Rejected commands reply at once; any bytes that follow are parsed
          // as fresh commands.
          if (reject) begin
            ld                     = 1'b1;
            ld_data[RESP_W-1 -: 8] = ERR;
            ld_len                 = 4'd1;
            state_d                = S_TX;
          end
        end
      end

      S_ARGS: begin
        if (rx_hs) begin
          arg_d = arg_shift;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_EXEC;
            // GPO is written directly on the last byte so the new value is
            // visible in the very next cycle.
            if (op_q == OP_GPO_WR) begin
              for (int k = 0; k < N_CH; k++) begin
                if (ch_q == 4'(k)) gpo_d[k*GPIO_W +: GPIO_W] = arg_shift[GPIO_W-1:0];
              end
            end
          end
        end
`ifdef UARTPROBE_RX_TIMEOUT_EN
        if (rx_hs) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_W'(RX_TIMEOUT - 1)) begin
          ld                     = 1'b1;
          ld_data[RESP_W-1 -: 8] = TMO;
          ld_len                 = 4'd1;
          state_d                = S_TX;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      S_EXEC: begin
        case (op_q)
          OP_AXI_WR: begin
            awaddr_d  = arg_q[63:32];
            wdata_d   = arg_q[31:0];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_AXI_AW_W;
          end
          OP_AXI_RD: begin
            araddr_d  = arg_q[31:0];
            arvalid_d = 1'b1;
            state_d   = S_AXI_AR;
          end
          default: begin
            ld                     = 1'b1;
            ld_data[RESP_W-1 -: 8] = ACK;
            ld_len                 = 4'd1;
            state_d                = S_TX;
          end
        endcase
      end

      S_AXI_AW_W: begin
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = S_AXI_B;
      end

      S_AXI_B: begin
        if (m_axi_bvalid) begin
          ld                     = 1'b1;
          ld_data[RESP_W-1 -: 8] = {6'b0, m_axi_bresp};
          ld_len                 = 4'd1;
          state_d                = S_TX;
        end
      end

      S_AXI_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_AXI_R;
        end
      end

      S_AXI_R: begin
        if (m_axi_rvalid) begin
          ld                      = 1'b1;
          ld_data[RESP_W-1 -: 40] = {6'b0, m_axi_rresp, m_axi_rdata};
          ld_len                  = 4'd5;
          state_d                 = S_TX;
        end
      end

      S_TX: begin
        if (tx_done) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      ch_q      <= '0;
      cnt_q     <= '0;
      arg_q     <= '0;
      gpo_q     <= {N_CH{GPO_RESET}};
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      arg_q     <= arg_d;
      gpo_q     <= gpo_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      araddr_q  <= araddr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
    end
  end

`ifdef UARTPROBE_RX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  uartprobe_txshift #(
    .BYTES (RB)
  ) u_txshift (
    .clk       (clk),
    .reset     (reset),
    .load      (ld),
    .load_data (ld_data),
    .load_len  (ld_len),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .done      (tx_done)
  );

  assign gpo           = gpo_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == S_AXI_B);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == S_AXI_R);

endmodule
